// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - DEPTH x WIDTH universal shift register with fill tracking
// Define USR_MULTI_SHIFT_EN to add shift_amt for multi-stage shifts and rotates.
module universal_shift_register #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2:0]               mode,
  input  logic [WIDTH-1:0]         in,
  input  logic [DEPTH*WIDTH-1:0]   load_data,
`ifdef USR_MULTI_SHIFT_EN
  input  logic [$clog2(DEPTH)-1:0] shift_amt,
`endif
  output logic [DEPTH*WIDTH-1:0]   out,
  output logic [WIDTH-1:0]         shift_out,
  output logic                     shift_out_valid,
  output logic [CW-1:0]            fill,
  output logic                     full,
  output logic                     empty
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'd0,
    M_SHL   = 3'd1,
    M_SHR   = 3'd2,
    M_ROL   = 3'd3,
    M_ROR   = 3'd4,
    M_LOAD  = 3'd5,
    M_CLEAR = 3'd6,
    M_RSVD  = 3'd7
  } mode_e;

  logic [DEPTH*WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0]       shift_out_q, shift_out_d;
  logic                   shift_out_valid_q, shift_out_valid_d;
  logic [CW-1:0]          fill_q, fill_d, fill_sat;
  int                     k;
  int                     src;
  int                     fill_sum;

`ifdef USR_MULTI_SHIFT_EN
  assign k = int'(shift_amt);
`else
  assign k = 1;
`endif

  always_comb begin
    data_d            = data_q;
    shift_out_d       = shift_out_q;
    shift_out_valid_d = 1'b0;
    fill_d            = fill_q;
    src               = 0;
    fill_sum          = int'(fill_q) + k;
    if (fill_sum >= DEPTH) fill_sat = CW'(DEPTH);
    else                   fill_sat = CW'(fill_sum);

    // A zero-stage shift or rotate degenerates to HOLD.
    if (enable) begin
      case (mode_e'(mode))
        M_SHL: if (k != 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            src = i - k;
            if (src < 0) data_d[i*WIDTH +: WIDTH] = in;
            else         data_d[i*WIDTH +: WIDTH] = data_q[src*WIDTH +: WIDTH];
          end
          shift_out_d       = data_q[(DEPTH-k)*WIDTH +: WIDTH];
          shift_out_valid_d = 1'b1;
          fill_d            = fill_sat;
        end
        M_SHR: if (k != 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            src = i + k;
            if (src >= DEPTH) data_d[i*WIDTH +: WIDTH] = in;
            else              data_d[i*WIDTH +: WIDTH] = data_q[src*WIDTH +: WIDTH];
          end
          shift_out_d       = data_q[(k-1)*WIDTH +: WIDTH];
          shift_out_valid_d = 1'b1;
          fill_d            = fill_sat;
        end
        M_ROL: begin
          for (int i = 0; i < DEPTH; i++) begin
            src = i - k;
            if (src < 0) src = src + DEPTH;
            data_d[i*WIDTH +: WIDTH] = data_q[src*WIDTH +: WIDTH];
          end
        end
        M_ROR: begin
          for (int i = 0; i < DEPTH; i++) begin
            src = i + k;
            if (src >= DEPTH) src = src - DEPTH;
            data_d[i*WIDTH +: WIDTH] = data_q[src*WIDTH +: WIDTH];
          end
        end
        M_LOAD: begin
          data_d = load_data;
          fill_d = CW'(DEPTH);
        end
        M_CLEAR: begin
          data_d      = '0;
          fill_d      = '0;
          shift_out_d = '0;
        end
        M_HOLD, M_RSVD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q            <= '0;
      shift_out_q       <= '0;
      shift_out_valid_q <= 1'b0;
      fill_q            <= '0;
    end else begin
      data_q            <= data_d;
      shift_out_q       <= shift_out_d;
      shift_out_valid_q <= shift_out_valid_d;
      fill_q            <= fill_d;
    end
  end

  assign out             = data_q;
  assign shift_out       = shift_out_q;
  assign shift_out_valid = shift_out_valid_q;
  assign fill            = fill_q;
  assign full            = (fill_q == CW'(DEPTH));
  assign empty           = (fill_q == '0);

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed and random checks of universal_shift_register
// Two instances (1x8 and 4x4) compared against a queue-based model of the stages.
module tb_universal_shift_register;

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3;
  localparam logic [2:0] ROR = 3'd4, LOAD = 3'd5, CLEAR = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_en = 1'b0, a_in = 1'b0;
  logic [2:0]  a_mode = 3'd0;
  logic [7:0]  a_load = '0, a_out;
  logic        a_so, a_sov, a_full, a_empty;
  logic [3:0]  a_fill;

  logic        b_en = 1'b0;
  logic [2:0]  b_mode = 3'd0;
  logic [3:0]  b_in = '0, b_so;
  logic [15:0] b_load = '0, b_out;
  logic        b_sov, b_full, b_empty;
  logic [2:0]  b_fill;
`ifdef USR_MULTI_SHIFT_EN
  logic [2:0]  a_amt = '0;
  logic [1:0]  b_amt = '0;
`endif

  universal_shift_register #(.WIDTH(1), .DEPTH(8)) u_a (
    .clk(clk), .reset(rst_n), .enable(a_en), .mode(a_mode), .in(a_in), .load_data(a_load),
`ifdef USR_MULTI_SHIFT_EN
    .shift_amt(a_amt),
`endif
    .out(a_out), .shift_out(a_so), .shift_out_valid(a_sov), .fill(a_fill),
    .full(a_full), .empty(a_empty)
  );

  universal_shift_register #(.WIDTH(4), .DEPTH(4)) u_b (
    .clk(clk), .reset(rst_n), .enable(b_en), .mode(b_mode), .in(b_in), .load_data(b_load),
`ifdef USR_MULTI_SHIFT_EN
    .shift_amt(b_amt),
`endif
    .out(b_out), .shift_out(b_so), .shift_out_valid(b_sov), .fill(b_fill),
    .full(b_full), .empty(b_empty)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cur      = 0;

  logic [3:0] m_q[$];
  int         m_d, m_w, m_fill;
  logic [3:0] m_mask, m_so;
  logic       m_sov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d, input int w);
    m_d = d;
    m_w = w;
    m_mask = 4'((1 << w) - 1);
    m_q.delete();
    for (int i = 0; i < d; i++) m_q.push_back(4'h0);
    m_fill = 0;
    m_so = '0;
    m_sov = 1'b0;
  endtask

  // Stage 0 is the queue front; a left shift pushes new words in at the front.
  task automatic model_step(input logic en, input logic [2:0] md, input logic [3:0] din,
                            input int k, input logic [15:0] ld);
    logic [3:0] lost;
    lost = '0;
    m_sov = 1'b0;
    if (en) begin
      case (md)
        SHL, SHR: if (k > 0) begin
          for (int j = 0; j < k; j++) begin
            if (md == SHL) begin
              lost = m_q.pop_back();
              m_q.push_front(din & m_mask);
            end else begin
              lost = m_q.pop_front();
              m_q.push_back(din & m_mask);
            end
          end
          m_so = lost;
          m_sov = 1'b1;
          m_fill = (m_fill + k > m_d) ? m_d : m_fill + k;
        end
        ROL: for (int j = 0; j < k; j++) m_q.push_front(m_q.pop_back());
        ROR: for (int j = 0; j < k; j++) m_q.push_back(m_q.pop_front());
        LOAD: begin
          for (int i = 0; i < m_d; i++) m_q[i] = 4'(ld >> (i * m_w)) & m_mask;
          m_fill = m_d;
        end
        CLEAR: begin
          for (int i = 0; i < m_d; i++) m_q[i] = 4'h0;
          m_fill = 0;
          m_so = '0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] e_out, o_out, o_so, o_fill;
    logic        o_sov, o_full, o_empty;
    e_out = '0;
    for (int i = 0; i < m_d; i++) e_out = e_out | (32'(m_q[i]) << (i * m_w));
    if (cur == 0) begin
      o_out = 32'(a_out); o_so = 32'(a_so); o_fill = 32'(a_fill);
      o_sov = a_sov; o_full = a_full; o_empty = a_empty;
    end else begin
      o_out = 32'(b_out); o_so = 32'(b_so); o_fill = 32'(b_fill);
      o_sov = b_sov; o_full = b_full; o_empty = b_empty;
    end
    chk({tag, "/out"}, o_out, e_out);
    chk({tag, "/shift_out"}, o_so, 32'(m_so));
    chk({tag, "/valid"}, 32'(o_sov), 32'(m_sov));
    chk({tag, "/fill"}, o_fill, 32'(m_fill));
    chk({tag, "/full"}, 32'(o_full), 32'(m_fill == m_d));
    chk({tag, "/empty"}, 32'(o_empty), 32'(m_fill == 0));
  endtask

  task automatic step(input logic en, input logic [2:0] md, input logic [3:0] din,
                      input int k, input logic [15:0] ld, input string tag);
    a_en = (cur == 0) ? en : 1'b0;
    a_mode = md; a_in = din[0]; a_load = ld[7:0];
    b_en = (cur == 1) ? en : 1'b0;
    b_mode = md; b_in = din; b_load = ld;
`ifdef USR_MULTI_SHIFT_EN
    a_amt = 3'(k);
    b_amt = 2'(k);
`endif
    @(posedge clk);
    #1;
    model_step(en, md, din, k, ld);
    check_state(tag);
  endtask

  function automatic int rand_k(input int maxk);
`ifdef USR_MULTI_SHIFT_EN
    return int'($urandom_range(0, maxk));
`else
    return (maxk > 0) ? 1 : 1;
`endif
  endfunction

  initial begin
    int sbits[7];
    sbits = '{1, 1, 0, 1, 0, 1, 1};

    #2 rst_n = 1'b0;
    #1;
    model_reset(8, 1);
    cur = 0;
    check_state("reset_a");
    chk("reset_b/out", 32'(b_out), 32'h0);
    chk("reset_b/empty", 32'(b_empty), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) step(1'b1, SHL, 4'(sbits[i]), 1, 16'h0, "shl_serial");
    chk("serial7/out", 32'(a_out), 32'b01101011);
    chk("serial7/fill", 32'(a_fill), 32'd7);
    step(1'b1, SHL, 4'h1, 1, 16'h0, "shl_8th");
    chk("serial8/out", 32'(a_out), 32'b11010111);
    chk("serial8/full", 32'(a_full), 32'h1);

    for (int i = 0; i < 5; i++) step(1'b0, SHL, 4'h1, 1, 16'h0, "disabled");
    chk("disabled/out", 32'(a_out), 32'b11010111);

    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
           rand_k(7), 16'($urandom), "rand_a");

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst/out", 32'(a_out), 32'h0);
    chk("async_rst/fill", 32'(a_fill), 32'h0);
    chk("async_rst/empty", 32'(a_empty), 32'h1);
    model_reset(8, 1);
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, SHL, 4'h1, 1, 16'h0, "refill");
    step(1'b1, CLEAR, 4'h0, 1, 16'h0, "clear");
    chk("clear/out", 32'(a_out), 32'h0);
    chk("clear/fill", 32'(a_fill), 32'h0);
    chk("clear/empty", 32'(a_empty), 32'h1);

    cur = 1;
    model_reset(4, 4);
    check_state("b_idle");
    step(1'b1, LOAD, 4'h0, 1, 16'hA5C3, "load_a5c3");
    step(1'b1, SHR, 4'hF, 1, 16'h0, "shr_f");
    chk("shr/out", 32'(b_out), 32'hFA5C);
    chk("shr/shift_out", 32'(b_so), 32'h3);
    chk("shr/valid", 32'(b_sov), 32'h1);
    step(1'b1, HOLD, 4'h0, 1, 16'h0, "after_shr");
    chk("shr_pulse/valid", 32'(b_sov), 32'h0);

    step(1'b1, LOAD, 4'h0, 1, 16'h1234, "load_1234");
    step(1'b1, ROL, 4'h0, 1, 16'h0, "rol");
    chk("rol/out", 32'(b_out), 32'h2341);
    step(1'b1, ROR, 4'h0, 1, 16'h0, "ror");
    chk("ror/out", 32'(b_out), 32'h1234);
    chk("ror/fill", 32'(b_fill), 32'h4);
    chk("ror/valid", 32'(b_sov), 32'h0);

`ifdef USR_MULTI_SHIFT_EN
    step(1'b1, LOAD, 4'h0, 0, 16'h1234, "load_multi");
    step(1'b1, SHL, 4'hE, 2, 16'h0, "shl_k2");
    chk("shl_k2/out", 32'(b_out), 32'h34EE);
    chk("shl_k2/shift_out", 32'(b_so), 32'h2);
    step(1'b1, SHL, 4'h7, 0, 16'h0, "shl_k0");
`endif

    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
           rand_k(3), 16'($urandom), "rand_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
